// File: rtl/unit_joint_arbiter.sv
// rtl/unit_joint_arbiter.sv - packet-locked NCH-to-1 stream joiner with 2-entry output skid buffer
// Optional JOINT_RR_EN: round-robin arbitration instead of the fixed sel-driven select.
module unit_joint_arbiter #(
  parameter int  WIDTH = 1024,
  parameter int  NCH   = 2,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SELW-1:0]       sel,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH-1:0]        in_last,
  input  logic [NCH*WIDTH-1:0]  in_data,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SELW-1:0]       out_src,
  output logic [15:0]           pkt_cnt
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [SELW-1:0]   g;
  logic [1:0]        count;
  logic [WIDTH-1:0]  head_data, tail_data;
  logic              head_last, tail_last;
  logic [SELW-1:0]   head_src, tail_src;

  logic              g_valid, g_last;
  logic [WIDTH-1:0]  g_data;
  logic [SELW-1:0]   cand;
  logic              cand_ok;
  logic              push, pop, pkt_done;

  // Route the granted channel's stream and build the one-hot ready.
  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (g == SELW'(i)) begin
        g_valid     = in_valid[i];
        g_last      = in_last[i];
        g_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = (state == LOCK) && (count != 2'd2);
      end
    end
  end

  assign push     = (state == LOCK) && g_valid && (count != 2'd2);
  assign pop      = (count != 2'd0) && out_ready;
  assign pkt_done = pop && head_last;

`ifdef JOINT_RR_EN
  logic [SELW-1:0] rr_ptr;
  logic            unused_sel;

  assign unused_sel = ^sel;

  // First valid channel searching upward from the channel after the last grant.
  always_comb begin
    int idx;
    idx     = 0;
    cand    = '0;
    cand_ok = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!cand_ok && in_valid[idx]) begin
        cand_ok = 1'b1;
        cand    = SELW'(idx);
      end
    end
  end
`else
  // An out-of-range sel matches no channel, so no grant is ever taken.
  always_comb begin
    cand    = sel;
    cand_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) cand_ok = in_valid[i];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      g      <= '0;
`ifdef JOINT_RR_EN
      rr_ptr <= SELW'(NCH - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cand_ok) begin
            g      <= cand;
            state  <= LOCK;
`ifdef JOINT_RR_EN
            rr_ptr <= cand;
`endif
          end
        end
        LOCK: begin
          if (push && g_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid buffer: head always drives the outputs, tail only holds the second entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      head_src  <= '0;
      tail_data <= '0;
      tail_last <= 1'b0;
      tail_src  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_data <= g_data;
            head_last <= g_last;
            head_src  <= g;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data <= g_data;
            head_last <= g_last;
            head_src  <= g;
          end else if (push) begin
            tail_data <= g_data;
            tail_last <= g_last;
            tail_src  <= g;
            count     <= 2'd2;
          end else if (pop) begin
            count     <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_data <= tail_data;
            head_last <= tail_last;
            head_src  <= tail_src;
            count     <= 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= 16'd0;
    end else if (pkt_done) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = head_data;
  assign out_last  = head_last;
  assign out_src   = head_src;

endmodule
